// File: rtl/sev_seg_pkg.sv
// Package for the multiplexed 7-segment driver.
// Holds the segment glyph constants (bit order [1:7] = a..g, active-high)
// and the nibble-to-glyph decode function shared by the decoder.
package sev_seg_pkg;

  localparam logic [1:7] SEG_0   = 7'b1111110;
  localparam logic [1:7] SEG_1   = 7'b0110000;
  localparam logic [1:7] SEG_2   = 7'b1101101;
  localparam logic [1:7] SEG_3   = 7'b1111001;
  localparam logic [1:7] SEG_4   = 7'b0110011;
  localparam logic [1:7] SEG_5   = 7'b1011011;
  localparam logic [1:7] SEG_6   = 7'b1011111;
  localparam logic [1:7] SEG_7   = 7'b1110000;
  localparam logic [1:7] SEG_8   = 7'b1111111;
  localparam logic [1:7] SEG_9   = 7'b1111011;
  localparam logic [1:7] SEG_A   = 7'b1110111;
  localparam logic [1:7] SEG_B   = 7'b0011111;
  localparam logic [1:7] SEG_C   = 7'b1001110;
  localparam logic [1:7] SEG_D   = 7'b0111101;
  localparam logic [1:7] SEG_E   = 7'b1001111;
  localparam logic [1:7] SEG_F   = 7'b1000111;
  localparam logic [1:7] SEG_OFF = 7'b0000000;

  // Logical (active-high) glyph for one nibble; codes 10-15 go dark
  // unless hex_mode is set.
  function automatic logic [1:7] decode(input logic [3:0] nibble, input logic hex_mode);
    logic [1:7] g;
    case (nibble)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = hex_mode ? SEG_A : SEG_OFF;
      4'hB:    g = hex_mode ? SEG_B : SEG_OFF;
      4'hC:    g = hex_mode ? SEG_C : SEG_OFF;
      4'hD:    g = hex_mode ? SEG_D : SEG_OFF;
      4'hE:    g = hex_mode ? SEG_E : SEG_OFF;
      4'hF:    g = hex_mode ? SEG_F : SEG_OFF;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hex_to_sev.sv
// Combinational nibble-to-glyph decoder.
// Ports:
//   nibble : 4-bit digit code
//   glyph  : segments a..g (glyph[1]=a), active-high, before pin polarity
module hex_to_sev
  import sev_seg_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] nibble,
  output logic [1:7] glyph
);

  assign glyph = decode(nibble, HEX_MODE != 0);

endmodule

// File: rtl/sev_seg_scan.sv
// Time-multiplexed N-digit 7-segment display driver.
// Shadow-registers the operand digits, scans one digit per refresh slot with
// a leading dead-time (all anodes off), and drives registered seg/dp/an pins.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture data_in/dp_in/blank_in into the shadow registers
//   data_in    : one nibble per digit, nibble 0 is the least significant digit
//   dp_in      : decimal point per digit
//   blank_in   : force a digit dark (anode timing unchanged)
//   lz_en      : leading-zero suppression, used live
//   seg, dp    : segment and decimal-point pins (polarity per SEG_ACTIVE_LOW)
//   an         : digit select pins (polarity per AN_ACTIVE_LOW)
//   digit_idx  : digit currently owning the slot
module sev_seg_scan
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int DEAD_CYC       = 2,
  parameter int HEX_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1,
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  output logic [1:7]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  // XOR masks that map logical "on" to the pin level; the reset value of
  // each pin register is its mask, i.e. everything off/deselected.
  localparam logic [1:7]            SEG_INV = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] data_r;
  logic [NUM_DIGITS-1:0]   dpsh_r;
  logic [NUM_DIGITS-1:0]   blank_r;
  logic [1:7]              seg_r;
  logic                    dpo_r;
  logic [NUM_DIGITS-1:0]   an_r;

  logic                    wrap_s;
  logic                    dead_s;
  logic [3:0]              nib_s;
  logic [1:7]              glyph_s;
  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic                    zero_above_s;
  logic [1:7]              seg_nx_s;
  logic                    dp_nx_s;
  logic [NUM_DIGITS-1:0]   an_nx_s;

  assign wrap_s = (cnt_r == CNT_W'(REFRESH_DIV - 1));
  assign dead_s = (cnt_r < CNT_W'(DEAD_CYC));
  assign nib_s  = data_r[4*idx_r +: 4];

  hex_to_sev #(.HEX_MODE(HEX_MODE)) u_dec (
    .nibble (nib_s),
    .glyph  (glyph_s)
  );

  // Refresh divider and digit pointer: advance to the next digit on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (wrap_s) begin
      cnt_r <= '0;
      idx_r <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      idx_r <= idx_r;
    end
  end

  // Shadow registers: the scan only ever reads these, never the live inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= '0;
      dpsh_r  <= '0;
      blank_r <= '0;
    end else if (load) begin
      data_r  <= data_in;
      dpsh_r  <= dp_in;
      blank_r <= blank_in;
    end else begin
      data_r  <= data_r;
      dpsh_r  <= dpsh_r;
      blank_r <= blank_r;
    end
  end

  // Leading-zero mask: bit k set when digit k and every digit above it are
  // zero; digit 0 is excluded so a value of zero still shows one '0'.
  always_comb begin
    zero_above_s = 1'b1;
    lz_mask_s    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above_s = zero_above_s & (data_r[4*k +: 4] == 4'h0);
      lz_mask_s[k] = zero_above_s & (k > 0);
    end
  end

  // Next pin state in logical polarity: dead-time, then blank, then
  // leading-zero suppression (keeps dp), then the decoded glyph.
  always_comb begin
    seg_nx_s = SEG_OFF;
    dp_nx_s  = 1'b0;
    an_nx_s  = '0;
    if (dead_s) begin
      seg_nx_s = SEG_OFF;
      dp_nx_s  = 1'b0;
      an_nx_s  = '0;
    end else begin
      an_nx_s = NUM_DIGITS'(1) << idx_r;
      if (blank_r[idx_r]) begin
        seg_nx_s = SEG_OFF;
        dp_nx_s  = 1'b0;
      end else if (lz_en && lz_mask_s[idx_r]) begin
        seg_nx_s = SEG_OFF;
        dp_nx_s  = dpsh_r[idx_r];
      end else begin
        seg_nx_s = glyph_s;
        dp_nx_s  = dpsh_r[idx_r];
      end
    end
  end

  // Registered pins with polarity applied after decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= SEG_INV;
      dpo_r <= DP_INV;
      an_r  <= AN_INV;
    end else begin
      seg_r <= seg_nx_s ^ SEG_INV;
      dpo_r <= dp_nx_s ^ DP_INV;
      an_r  <= an_nx_s ^ AN_INV;
    end
  end

  assign seg       = seg_r;
  assign dp        = dpo_r;
  assign an        = an_r;
  assign digit_idx = idx_r;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Self-checking bench for sev_seg_scan (4 digits, 4-cycle slots, 1 dead cycle).
// Three instances share the stimulus: the main one (hex, active-high segments),
// one with hex glyphs disabled and one with active-low segments.
module tb_sev_seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DC = 1;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;

  logic [1:7]  seg_m, seg_h, seg_a;
  logic        dp_m, dp_h, dp_a;
  logic [3:0]  an_m, an_h, an_a;
  logic [1:0]  idx_m, idx_h, idx_a;

  sev_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYC(DC), .HEX_MODE(1),
                 .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg(seg_m), .dp(dp_m), .an(an_m),
    .digit_idx(idx_m));

  sev_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYC(DC), .HEX_MODE(0),
                 .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut_h0 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg(seg_h), .dp(dp_h), .an(an_h),
    .digit_idx(idx_h));

  sev_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYC(DC), .HEX_MODE(1),
                 .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg(seg_a), .dp(dp_a), .an(an_a),
    .digit_idx(idx_a));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_h0;
    logic       dp;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (pre-edge view)
  int         m_cnt;
  int         m_idx;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;

  function automatic logic [6:0] glyph(input logic [3:0] n, input bit hex);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return hex ? 7'b1110111 : 7'b0000000;
      4'hB: return hex ? 7'b0011111 : 7'b0000000;
      4'hC: return hex ? 7'b1001110 : 7'b0000000;
      4'hD: return hex ? 7'b0111101 : 7'b0000000;
      4'hE: return hex ? 7'b1001111 : 7'b0000000;
      default: return hex ? 7'b1000111 : 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [3:0] nib;
    bit lz;
    e.an = 4'b1111; e.seg = 7'd0; e.seg_h0 = 7'd0; e.dp = 1'b0; e.idx = 2'd0;
    if (!rst && m_cnt >= DC) begin
      e.an = ~(4'b0001 << m_idx);
      nib  = m_data[m_idx*4 +: 4];
      lz   = 1'b0;
      if (lz_en && m_idx > 0) begin
        lz = 1'b1;
        for (int k = m_idx; k < ND; k++)
          if (m_data[k*4 +: 4] != 4'h0) lz = 1'b0;
      end
      if (m_blank[m_idx]) begin
        e.dp = 1'b0;
      end else if (lz) begin
        e.dp = m_dp[m_idx];
      end else begin
        e.seg    = glyph(nib, 1'b1);
        e.seg_h0 = glyph(nib, 1'b0);
        e.dp     = m_dp[m_idx];
      end
    end
    return e;
  endfunction

  // One clock: push the expected pins, advance the model, clock, pop and compare.
  task automatic step();
    exp_t e;
    e = model_out();
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_data = 16'h0; m_dp = 4'h0; m_blank = 4'h0;
    end else begin
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt++;
      end
      if (load) begin
        m_data = data_in; m_dp = dp_in; m_blank = blank_in;
      end
    end
    e.idx = 2'(m_idx);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("an",     32'(an_m),  32'(e.an));
    chk("seg",    32'(seg_m), 32'(e.seg));
    chk("dp",     32'(dp_m),  32'(e.dp));
    chk("idx",    32'(idx_m), 32'(e.idx));
    chk("h0_seg", 32'(seg_h), 32'(e.seg_h0));
    chk("al_seg", 32'(seg_a), {25'd0, ~e.seg});
    chk("al_dp",  32'(dp_a),  {31'd0, ~e.dp});
  endtask

  // Step until the model sits at (digit d, count c) before the next edge.
  task automatic wait_state(input int d, input int c);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_idx == d && m_cnt == c) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $error("FAIL wait_timeout: observed no slot d=%0d c=%0d expected reached", d, c);
    end
  endtask

  // Leaves the bench in the first visible cycle of digit d.
  task automatic goto(input int d);
    wait_state(d, DC);
    step();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0; lz_en = 1'b0;
    m_cnt = 0; m_idx = 0; m_data = 16'h0; m_dp = 4'h0; m_blank = 4'h0;
    step();
    step();
    chk("rst_an",  32'(an_m),  32'h0000000f);
    chk("rst_seg", 32'(seg_m), 32'h00000000);
    chk("rst_al",  32'(seg_a), 32'h0000007f);

    // Basic scan of 1234
    rst = 1'b0; load = 1'b1; data_in = 16'h1234;
    step();
    load = 1'b0;
    wait_state(0, 0); step();
    chk("dead_an", 32'(an_m), 32'h0000000f);
    chk("dead_seg", 32'(seg_m), 32'h00000000);
    goto(0); chk("d0_an", 32'(an_m), 32'he); chk("d0_seg", 32'(seg_m), 32'b0110011);
    goto(1); chk("d1_an", 32'(an_m), 32'hd); chk("d1_seg", 32'(seg_m), 32'b1111001);
    goto(2); chk("d2_seg", 32'(seg_m), 32'b1101101);
    goto(3); chk("d3_an", 32'(an_m), 32'h7); chk("d3_seg", 32'(seg_m), 32'b0110000);
    goto(0); chk("d0_idx", 32'(idx_m), 32'h0);

    // Hex glyphs, and dark 10-15 with hex disabled
    load = 1'b1; data_in = 16'hABCF;
    step();
    load = 1'b0;
    goto(0); chk("hexF", 32'(seg_m), 32'b1000111);
    chk("h0F_seg", 32'(seg_h), 32'h0); chk("h0F_an", 32'(an_h), 32'he);
    goto(3); chk("hexA", 32'(seg_m), 32'b1110111);

    // Leading-zero suppression keeps dp
    load = 1'b1; data_in = 16'h0050; dp_in = 4'b1000; lz_en = 1'b1;
    step();
    load = 1'b0;
    goto(3); chk("lz3_seg", 32'(seg_m), 32'h0); chk("lz3_dp", 32'(dp_m), 32'h1);
    goto(2); chk("lz2_seg", 32'(seg_m), 32'h0);
    goto(1); chk("lz1_seg", 32'(seg_m), 32'b1011011);
    goto(0); chk("lz0_seg", 32'(seg_m), 32'b1111110);
    lz_en = 1'b0;
    goto(2); chk("nolz2", 32'(seg_m), 32'b1111110);
    goto(3); chk("nolz3", 32'(seg_m), 32'b1111110); chk("nolz3_dp", 32'(dp_m), 32'h1);

    // Per-digit blank
    load = 1'b1; data_in = 16'h8888; dp_in = 4'b0010; blank_in = 4'b0010;
    step();
    load = 1'b0;
    goto(1); chk("blk_seg", 32'(seg_m), 32'h0); chk("blk_dp", 32'(dp_m), 32'h0);
    chk("blk_an", 32'(an_m), 32'hd);
    goto(0); chk("blk0", 32'(seg_m), 32'b1111111);

    // Load on the wrap edge: that cycle still shows the old digit
    wait_state(2, RD - 1);
    load = 1'b1; data_in = 16'h9999; dp_in = 4'h0; blank_in = 4'h0;
    step();
    load = 1'b0;
    chk("wrap_old", 32'(seg_m), 32'b1111111); chk("wrap_an", 32'(an_m), 32'hb);
    goto(3); chk("wrap_new3", 32'(seg_m), 32'b1111011);
    goto(0); chk("wrap_new0", 32'(seg_m), 32'b1111011);

    // Reset mid-slot
    wait_state(2, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_an", 32'(an_m), 32'hf); chk("mrst_seg", 32'(seg_m), 32'h0);
    chk("mrst_idx", 32'(idx_m), 32'h0);
    chk("mrst_alseg", 32'(seg_a), 32'h7f); chk("mrst_aldp", 32'(dp_a), 32'h1);
    goto(0); chk("post0", 32'(seg_m), 32'b1111110); chk("post0_an", 32'(an_m), 32'he);
    lz_en = 1'b1;
    goto(1); chk("post1_lz", 32'(seg_m), 32'h0);
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
